wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter directly upstream of memory_controller; its slave port drives the controller's cpu_* bus.
- Master 0 is the instruction-fetch port and master 1 is the load/store port of the core.
- Arbitration is round-robin; a grant is held for a full transaction.
- A watchdog terminates transactions whose slave never acknowledges and returns ERR to the requesting master.

Parameters:
ADDR_SIZE, 32, address width in bits
BYTE_AMNT, 4, bytes per data word; DAT width = 8*BYTE_AMNT, SEL width = BYTE_AMNT
TIMEOUT_CYCLES, 1024, BUSY cycles without ACK before ERR; legal range 2..65535

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  synchronous active-high reset
m0_CYC_I, m0_STB_I, m0_WE_I  in  1 each  master 0 cycle, strobe, write enable
m0_SEL_I  in  BYTE_AMNT  master 0 byte select
m0_ADR_I  in  ADDR_SIZE  master 0 address
m0_DAT_I  in  8*BYTE_AMNT  master 0 write data
m0_DAT_O  out  8*BYTE_AMNT  master 0 read data
m0_ACK_O, m0_ERR_O  out  1 each  master 0 acknowledge, error
m1_CYC_I, m1_STB_I, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I, m1_DAT_O, m1_ACK_O, m1_ERR_O: same as m0_* for master 1
s_CYC_O, s_STB_O, s_WE_O  out  1 each  to memory_controller cpu_CYC_I, cpu_STB_I, cpu_WE_I
s_SEL_O  out  BYTE_AMNT  to cpu_SEL_I
s_ADR_O  out  ADDR_SIZE  to cpu_ADR_I
s_DAT_O  out  8*BYTE_AMNT  to cpu_DAT_I
s_DAT_I  in  8*BYTE_AMNT  from cpu_DAT_O
s_ACK_I  in  1  from cpu_ACK_O

Behaviour:
- Request definition: mX_req = mX_CYC_I & mX_STB_I.
- FSM states:
  - IDLE: if no request, stay. If exactly one master requests, grant it. If both request, grant the master not equal to last_grant. Update last_grant, clear the counter, go to BUSY.
  - BUSY: s_CYC_O = s_STB_O = 1. s_WE_O, s_SEL_O, s_ADR_O and s_DAT_O are a combinational mux from the granted master's inputs.
    - s_ACK_I = 1: grantee ACK_O = 1 in the same cycle (combinational); go to RELEASE.
    - Else, grantee req drops (abort): go to RELEASE with no ACK or ERR.
    - Else, counter == TIMEOUT_CYCLES-1: grantee ERR_O = 1 for that cycle; go to RELEASE.
    - Else, counter increments.
  - RELEASE: exactly one cycle with all slave outputs 0 and all master ACK/ERR 0; then go to IDLE. This guarantees the controller sees CYC low between transactions and ignores a master's stale CYC.
- Output defaults outside BUSY: s_CYC_O, s_STB_O, s_WE_O = 0; s_SEL_O, s_ADR_O, s_DAT_O = 0. ACK_O and ERR_O are only ever asserted to the grantee while in BUSY.
- Read data: grantee mX_DAT_O = s_DAT_I; the non-granted master's DAT_O = 0.
- Latency: request first high at edge n → s_CYC_O high from edge n+1. A repeated request from the same master is re-arbitrated in IDLE at the earliest 2 cycles after its ACK.
- Simultaneous events:
  - ACK and timeout in the same cycle: ACK wins and ERR stays 0.
  - ACK while the grantee drops req: ACK is still routed and the slave transaction completes.
  - A request from the other master during BUSY is held off (no ACK) until IDLE.
- Reset: state = IDLE, last_grant = 1 (master 0 wins the first tie), counter = 0, all outputs 0. Reset asserted mid-BUSY drops s_CYC_O in the next cycle and emits no ACK or ERR.
- The counter is at least 16 bits wide and never wraps; it is cleared on every grant.

Test Plan:
- Single read: m0 requests ADR 0x00000004, slave returns 0xDEADBEEF with ACK 3 cycles later → s_ADR_O = 0x4, s_WE_O = 0 while BUSY; m0_ACK_O pulses 1 cycle with m0_DAT_O = 0xDEADBEEF; m1_ACK_O stays 0; s_CYC_O low for one RELEASE cycle.
- Tie after reset: m0 and m1 request at the same edge → m0 granted first, then m1 (s_ADR_O switches to m1's 0x01000010, WE = 1, SEL = 0x5); a third simultaneous tie grants m0.
- Back-to-back from m1: m1 keeps CYC asserted across 4 writes to 0x01000000..0x0100000C → 4 ACKs, each separated by RELEASE and IDLE cycles (≥2 idle cycles); write data passes unchanged.
- Timeout: TIMEOUT_CYCLES = 8, slave never ACKs → m1_ERR_O pulses exactly 8 cycles after grant, no ACK; the next request is granted normally.
- Abort: m0 drops CYC at BUSY cycle 2, ACK never arrives → RELEASE, then IDLE; no ACK or ERR; the pending m1 request is granted next.
- Reset mid-BUSY: RST_I high for 1 cycle during an m0 transaction → all outputs 0 on the following cycle; a late s_ACK_I is not forwarded; after reset a tie again grants m0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter feeding the memory controller's cpu_* bus.
// A grant is held for one whole transaction; a watchdog answers ERR if the slave never ACKs.
module wb_bus_arbiter #(
    parameter int ADDR_SIZE      = 32,
    parameter int BYTE_AMNT      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,

    input  logic                   m0_CYC_I,
    input  logic                   m0_STB_I,
    input  logic                   m0_WE_I,
    input  logic [BYTE_AMNT-1:0]   m0_SEL_I,
    input  logic [ADDR_SIZE-1:0]   m0_ADR_I,
    input  logic [8*BYTE_AMNT-1:0] m0_DAT_I,
    output logic [8*BYTE_AMNT-1:0] m0_DAT_O,
    output logic                   m0_ACK_O,
    output logic                   m0_ERR_O,

    input  logic                   m1_CYC_I,
    input  logic                   m1_STB_I,
    input  logic                   m1_WE_I,
    input  logic [BYTE_AMNT-1:0]   m1_SEL_I,
    input  logic [ADDR_SIZE-1:0]   m1_ADR_I,
    input  logic [8*BYTE_AMNT-1:0] m1_DAT_I,
    output logic [8*BYTE_AMNT-1:0] m1_DAT_O,
    output logic                   m1_ACK_O,
    output logic                   m1_ERR_O,

    output logic                   s_CYC_O,
    output logic                   s_STB_O,
    output logic                   s_WE_O,
    output logic [BYTE_AMNT-1:0]   s_SEL_O,
    output logic [ADDR_SIZE-1:0]   s_ADR_O,
    output logic [8*BYTE_AMNT-1:0] s_DAT_O,
    input  logic [8*BYTE_AMNT-1:0] s_DAT_I,
    input  logic                   s_ACK_I
);

    localparam int                CW        = 16;
    localparam logic [CW-1:0]     LAST_TICK = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            lastGrant_q, lastGrant_d;
    logic [CW-1:0]   count_q, count_d;

    logic            m0Req, m1Req, grantReq, active;
    logic            ackGrant, errGrant;

    assign m0Req    = m0_CYC_I & m0_STB_I;
    assign m1Req    = m1_CYC_I & m1_STB_I;
    assign grantReq = grant_q ? m1Req : m0Req;
    assign active   = (state_q == BUSY);

    // lastGrant resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        count_d     = count_q;
        unique case (state_q)
            IDLE: begin
                if (m0Req || m1Req) begin
                    grant_d     = (m0Req && m1Req) ? ~lastGrant_q : m1Req;
                    lastGrant_d = grant_d;
                    count_d     = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (s_ACK_I || !grantReq || count_q == LAST_TICK) begin
                    state_d = RELEASE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ACK outranks the watchdog; nothing is answered while reset is being applied.
    assign ackGrant = active & s_ACK_I & ~RST_I;
    assign errGrant = active & ~s_ACK_I & grantReq & (count_q == LAST_TICK) & ~RST_I;

    assign m0_ACK_O = ackGrant & ~grant_q;
    assign m1_ACK_O = ackGrant &  grant_q;
    assign m0_ERR_O = errGrant & ~grant_q;
    assign m1_ERR_O = errGrant &  grant_q;

    assign m0_DAT_O = (active && !grant_q) ? s_DAT_I : '0;
    assign m1_DAT_O = (active &&  grant_q) ? s_DAT_I : '0;

    assign s_CYC_O  = active;
    assign s_STB_O  = active;
    assign s_WE_O   = active & (grant_q ? m1_WE_I : m0_WE_I);
    assign s_SEL_O  = active ? (grant_q ? m1_SEL_I : m0_SEL_I) : '0;
    assign s_ADR_O  = active ? (grant_q ? m1_ADR_I : m0_ADR_I) : '0;
    assign s_DAT_O  = active ? (grant_q ? m1_DAT_I : m0_DAT_I) : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: read, ties, back-to-back writes, timeout, abort and reset.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int BA = 4;
    localparam int DW = 8 * BA;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic          m0_CYC_I, m0_STB_I, m0_WE_I;
    logic [BA-1:0] m0_SEL_I;
    logic [AW-1:0] m0_ADR_I;
    logic [DW-1:0] m0_DAT_I, m0_DAT_O;
    logic          m0_ACK_O, m0_ERR_O;
    logic          m1_CYC_I, m1_STB_I, m1_WE_I;
    logic [BA-1:0] m1_SEL_I;
    logic [AW-1:0] m1_ADR_I;
    logic [DW-1:0] m1_DAT_I, m1_DAT_O;
    logic          m1_ACK_O, m1_ERR_O;
    logic          s_CYC_O, s_STB_O, s_WE_O;
    logic [BA-1:0] s_SEL_O;
    logic [AW-1:0] s_ADR_O;
    logic [DW-1:0] s_DAT_O, s_DAT_I;
    logic          s_ACK_I;

    int checks   = 0;
    int failures = 0;

    wb_bus_arbiter #(.ADDR_SIZE(AW), .BYTE_AMNT(BA), .TIMEOUT_CYCLES(8)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I),
        .m0_SEL_I(m0_SEL_I), .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I),
        .m0_DAT_O(m0_DAT_O), .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
        .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I),
        .m1_SEL_I(m1_SEL_I), .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I),
        .m1_DAT_O(m1_DAT_O), .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O),
        .s_SEL_O(s_SEL_O), .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O),
        .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    // Inputs change 1 ns after the rising edge; checks run after a further 1 ns of settling.
    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int master, input logic req, input logic we,
                                 input logic [BA-1:0] sel, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] dat);
        if (master == 0) begin
            m0_CYC_I = req; m0_STB_I = req; m0_WE_I = we;
            m0_SEL_I = sel; m0_ADR_I = adr; m0_DAT_I = dat;
        end else begin
            m1_CYC_I = req; m1_STB_I = req; m1_WE_I = we;
            m1_SEL_I = sel; m1_ADR_I = adr; m1_DAT_I = dat;
        end
    endtask

    task automatic slave(input logic ack, input logic [DW-1:0] dat);
        s_ACK_I = ack;
        s_DAT_I = dat;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        RST_I = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slave(1'b0, 32'h0);
        tick(); tick();
        RST_I = 1'b0;
        settle();
        checkOutput("rst_s_cyc", s_CYC_O, 0);
        checkOutput("rst_s_adr", s_ADR_O, 0);
        checkOutput("rst_m0_ack", m0_ACK_O, 0);
        checkOutput("rst_m1_err", m1_ERR_O, 0);

        // Single read from m0, slave ACKs in the third BUSY cycle
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
        tick(); settle();
        checkOutput("rd_s_cyc", s_CYC_O, 1);
        checkOutput("rd_s_stb", s_STB_O, 1);
        checkOutput("rd_s_adr", s_ADR_O, 32'h4);
        checkOutput("rd_s_we", s_WE_O, 0);
        checkOutput("rd_early_ack", m0_ACK_O, 0);
        tick(); tick();
        slave(1'b1, 32'hDEAD_BEEF);
        settle();
        checkOutput("rd_m0_ack", m0_ACK_O, 1);
        checkOutput("rd_m0_dat", m0_DAT_O, 32'hDEAD_BEEF);
        checkOutput("rd_m1_ack", m1_ACK_O, 0);
        checkOutput("rd_m1_dat", m1_DAT_O, 0);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("rd_release_cyc", s_CYC_O, 0);
        checkOutput("rd_release_ack", m0_ACK_O, 0);
        tick(); settle();
        checkOutput("rd_idle_cyc", s_CYC_O, 0);

        // Tie after reset: m0, then m1, then m0 again
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 4'h5, 32'h0100_0010, 32'hCAFE_F00D);
        tick(); settle();
        checkOutput("tie1_adr", s_ADR_O, 32'h20);
        checkOutput("tie1_we", s_WE_O, 0);
        slave(1'b1, 32'h1234_5678);
        settle();
        checkOutput("tie1_m0_ack", m0_ACK_O, 1);
        checkOutput("tie1_m1_ack", m1_ACK_O, 0);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("tie1_release_cyc", s_CYC_O, 0);
        tick(); settle();
        checkOutput("tie1_idle_cyc", s_CYC_O, 0);
        tick(); settle();
        checkOutput("tie2_cyc", s_CYC_O, 1);
        checkOutput("tie2_adr", s_ADR_O, 32'h0100_0010);
        checkOutput("tie2_we", s_WE_O, 1);
        checkOutput("tie2_sel", s_SEL_O, 4'h5);
        checkOutput("tie2_dat", s_DAT_O, 32'hCAFE_F00D);
        slave(1'b1, 32'h0);
        settle();
        checkOutput("tie2_m1_ack", m1_ACK_O, 1);
        checkOutput("tie2_m0_ack", m0_ACK_O, 0);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 4'h3, 32'h0000_0030, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'h3, 32'h0100_0030, 32'h0);
        tick(); settle();
        checkOutput("tie3_adr", s_ADR_O, 32'h30);
        slave(1'b1, 32'h0);
        settle();
        checkOutput("tie3_m0_ack", m0_ACK_O, 1);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Back-to-back writes from m1 with CYC held high throughout
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 1'b1, 4'hF, 32'h0100_0000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
            tick(); settle();
            checkOutput("b2b_adr", s_ADR_O, 32'h0100_0000 + 32'(4 * i));
            checkOutput("b2b_dat", s_DAT_O, 32'hA5A5_0000 + 32'(i));
            checkOutput("b2b_we", s_WE_O, 1);
            slave(1'b1, 32'h0);
            settle();
            checkOutput("b2b_ack", m1_ACK_O, 1);
            tick();
            slave(1'b0, 32'h0);
            if (i == 3) applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            settle();
            checkOutput("b2b_release_cyc", s_CYC_O, 0);
            checkOutput("b2b_release_ack", m1_ACK_O, 0);
            tick(); settle();
            checkOutput("b2b_idle_cyc", s_CYC_O, 0);
        end

        // Timeout: slave never answers, ERR appears in the 8th BUSY cycle
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0100_0040, 32'h0);
        tick(); settle();
        for (int k = 1; k <= 7; k++) begin
            checkOutput("to_cyc", s_CYC_O, 1);
            checkOutput("to_early_err", m1_ERR_O, 0);
            tick(); settle();
        end
        checkOutput("to_err", m1_ERR_O, 1);
        checkOutput("to_ack", m1_ACK_O, 0);
        checkOutput("to_m0_err", m0_ERR_O, 0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("to_release_cyc", s_CYC_O, 0);
        checkOutput("to_release_err", m1_ERR_O, 0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0);
        tick(); settle();
        checkOutput("to_next_adr", s_ADR_O, 32'h44);
        slave(1'b1, 32'h0000_0077);
        settle();
        checkOutput("to_next_ack", m0_ACK_O, 1);
        checkOutput("to_next_dat", m0_DAT_O, 32'h77);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Abort: m0 withdraws in BUSY cycle 2 while m1 waits
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 4'hC, 32'h0100_0050, 32'h5555_AAAA);
        settle();
        checkOutput("ab_adr", s_ADR_O, 32'h50);
        checkOutput("ab_m1_held", m1_ACK_O, 0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("ab_m0_ack", m0_ACK_O, 0);
        checkOutput("ab_m0_err", m0_ERR_O, 0);
        tick(); settle();
        checkOutput("ab_release_cyc", s_CYC_O, 0);
        tick(); settle();
        checkOutput("ab_idle_cyc", s_CYC_O, 0);
        tick(); settle();
        checkOutput("ab_m1_adr", s_ADR_O, 32'h0100_0050);
        checkOutput("ab_m1_sel", s_SEL_O, 4'hC);
        slave(1'b1, 32'h0);
        settle();
        checkOutput("ab_m1_ack", m1_ACK_O, 1);
        tick();
        slave(1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Reset during an m0 transaction, late ACK must be ignored
        applyStimulus(0, 1'b1, 1'b1, 4'hF, 32'h0000_0060, 32'h1111_2222);
        tick(); settle();
        checkOutput("rs_busy_cyc", s_CYC_O, 1);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slave(1'b1, 32'hBAD0_BAD0);
        settle();
        checkOutput("rs_cyc", s_CYC_O, 0);
        checkOutput("rs_adr", s_ADR_O, 0);
        checkOutput("rs_m0_ack", m0_ACK_O, 0);
        checkOutput("rs_m0_err", m0_ERR_O, 0);
        checkOutput("rs_m0_dat", m0_DAT_O, 0);
        tick(); settle();
        checkOutput("rs_late_ack", m0_ACK_O, 0);
        slave(1'b0, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h0000_0070, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h0100_0070, 32'h0);
        tick(); settle();
        checkOutput("rs_tie_adr", s_ADR_O, 32'h70);
        checkOutput("rs_tie_cyc", s_CYC_O, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
